// File: rtl/serial_operand_feeder.sv
// rtl/serial_operand_feeder.sv - debounced step/clear keys feeding two operands out bit-serially, LSB first
module serial_operand_feeder #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       MAX10_CLK1_50,
    input  logic       reset,
    input  logic [1:0] KEY,
    input  logic [9:0] SW,
    output logic       a,
    output logic       b,
    output logic       first,
    output logic       bit_valid,
    output logic [2:0] bit_idx,
    output logic       busy,
    output logic       done,
    output logic       clear_pulse
);

    localparam int              CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]      IDX_LAST  = 3'(WIDTH - 1);
    localparam logic [2:0]      IDX_CARRY = 3'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            stable_q, stable_d;
    logic [1:0]            press_q, press_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

    state_t                state_q;
    logic [WIDTH-1:0]      op_a_q, op_b_q;
    logic                  a_q, b_q, first_q, bit_valid_q, busy_q, done_q, clear_pulse_q;
    logic [2:0]            bit_idx_q;
    logic [2:0]            idx_next;
    logic                  step_press, clear_press;

    // A key only flips after DEBOUNCE_CYCLES consecutive samples disagree with the stable value
    always_comb begin
        stable_d = stable_q;
        press_d  = '0;
        for (int k = 0; k < 2; k++) begin
            cnt_d[k] = '0;
            if (sync2_q[k] != stable_q[k]) begin
                if (cnt_q[k] == CNT_LAST) begin
                    stable_d[k] = sync2_q[k];
                    press_d[k]  = stable_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            stable_q <= 2'b11;
            cnt_q    <= '0;
            press_q  <= '0;
        end else begin
            sync1_q  <= KEY;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign step_press  = press_q[1];
    assign clear_press = press_q[0];
    assign idx_next    = bit_idx_q + 3'd1;

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            state_q       <= IDLE;
            op_a_q        <= '0;
            op_b_q        <= '0;
            a_q           <= 1'b0;
            b_q           <= 1'b0;
            first_q       <= 1'b0;
            bit_valid_q   <= 1'b0;
            bit_idx_q     <= 3'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            clear_pulse_q <= 1'b0;
        end else begin
            bit_valid_q   <= 1'b0;
            clear_pulse_q <= 1'b0;
            if (clear_press) begin
                state_q       <= IDLE;
                clear_pulse_q <= 1'b1;
                a_q           <= 1'b0;
                b_q           <= 1'b0;
                first_q       <= 1'b0;
                bit_idx_q     <= 3'd0;
                busy_q        <= 1'b0;
                done_q        <= 1'b0;
            end else if (step_press) begin
                case (state_q)
                    IDLE: begin
                        op_a_q      <= SW[WIDTH-1:0];
                        op_b_q      <= SW[2*WIDTH-1:WIDTH];
                        a_q         <= SW[0];
                        b_q         <= SW[WIDTH];
                        first_q     <= 1'b1;
                        bit_idx_q   <= 3'd0;
                        bit_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        state_q     <= (WIDTH == 1) ? FLUSH : SHIFT;
                    end
                    SHIFT: begin
                        a_q         <= op_a_q[idx_next];
                        b_q         <= op_b_q[idx_next];
                        first_q     <= 1'b0;
                        bit_idx_q   <= idx_next;
                        bit_valid_q <= 1'b1;
                        if (idx_next == IDX_LAST) begin
                            state_q <= FLUSH;
                        end
                    end
                    FLUSH: begin
                        // Extra all-zero bit lets the consumer shift out its final carry
                        a_q         <= 1'b0;
                        b_q         <= 1'b0;
                        first_q     <= 1'b0;
                        bit_idx_q   <= IDX_CARRY;
                        bit_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                    DONE: begin
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign a           = a_q;
    assign b           = b_q;
    assign first       = first_q;
    assign bit_valid   = bit_valid_q;
    assign bit_idx     = bit_idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign clear_pulse = clear_pulse_q;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// tb/tb_serial_operand_feeder.sv - directed bench with per-cycle reference model for serial_operand_feeder
module tb_serial_operand_feeder;

    localparam int W = 5;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] key_r;
    logic [9:0] sw_r;
    logic       a, b, first, bit_valid, busy, done, clear_pulse;
    logic [2:0] bit_idx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_operand_feeder #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .MAX10_CLK1_50(clk),
        .reset        (reset),
        .KEY          (key_r),
        .SW           (sw_r),
        .a            (a),
        .b            (b),
        .first        (first),
        .bit_valid    (bit_valid),
        .bit_idx      (bit_idx),
        .busy         (busy),
        .done         (done),
        .clear_pulse  (clear_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: keys seen two samples late, flipped after D disagreeing samples,
    // and the feeder reduced to "how many bits have been emitted since the last start".
    logic [1:0]   m_d1 = 2'b11, m_d2 = 2'b11, m_stable = 2'b11, m_evt = 2'b00;
    int           m_run [2] = '{0, 0};
    int           m_emitted = 0;
    logic [W-1:0] m_A = '0, m_B = '0;
    logic         e_a = 0, e_b = 0, e_first = 0, e_valid = 0, e_clr = 0;
    int           e_idx = 0;

    always @(posedge clk) begin
        logic [1:0] new_evt;
        logic       step, clr;
        if (reset) begin
            m_d1 = 2'b11; m_d2 = 2'b11; m_stable = 2'b11; m_evt = 2'b00;
            m_run[0] = 0; m_run[1] = 0; m_emitted = 0;
            e_a = 0; e_b = 0; e_first = 0; e_valid = 0; e_clr = 0; e_idx = 0;
        end else begin
            step = m_evt[1];
            clr  = m_evt[0];
            new_evt = 2'b00;
            for (int k = 0; k < 2; k++) begin
                if (m_d2[k] != m_stable[k]) begin
                    m_run[k]++;
                    if (m_run[k] == D) begin
                        m_stable[k] = m_d2[k];
                        m_run[k]    = 0;
                        new_evt[k]  = (m_stable[k] == 1'b0);
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_d2  = m_d1;
            m_d1  = key_r;
            m_evt = new_evt;
            e_valid = 0;
            e_clr   = 0;
            if (clr) begin
                m_emitted = 0;
                e_a = 0; e_b = 0; e_first = 0; e_idx = 0; e_clr = 1;
            end else if (step && m_emitted <= W) begin
                if (m_emitted == 0) begin
                    m_A = sw_r[W-1:0];
                    m_B = sw_r[2*W-1:W];
                end
                e_idx   = m_emitted;
                e_a     = (e_idx < W) ? m_A[e_idx] : 1'b0;
                e_b     = (e_idx < W) ? m_B[e_idx] : 1'b0;
                e_first = (e_idx == 0);
                e_valid = 1;
                m_emitted++;
            end
        end
        #1;
        check("a", a, e_a);
        check("b", b, e_b);
        check("first", first, e_first);
        check("bit_idx", bit_idx, e_idx);
        check("bit_valid", bit_valid, e_valid);
        check("clear_pulse", clear_pulse, e_clr);
        check("busy", busy, (m_emitted >= 1 && m_emitted <= W));
        check("done", done, (m_emitted == W + 1));
    end

    // Emission log for the literal checks below
    logic       log_a [64], log_b [64], log_first [64];
    logic [2:0] log_idx [64];
    int         log_cyc [64];
    int         log_n = 0;
    int         clr_n = 0;

    always @(posedge clk) begin
        #1;
        if (bit_valid === 1'b1 && log_n < 64) begin
            log_a[log_n] = a; log_b[log_n] = b; log_first[log_n] = first;
            log_idx[log_n] = bit_idx; log_cyc[log_n] = cyc;
            log_n++;
        end
        if (clear_pulse === 1'b1) clr_n++;
    end

    task automatic press(input int k, input int hold, output int t0);
        @(negedge clk);
        t0 = cyc;
        key_r[k] = 1'b0;
        repeat (hold) @(negedge clk);
        key_r[k] = 1'b1;
        repeat (D + 6) @(negedge clk);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_a"}, a, 0);
        check({tag, "_b"}, b, 0);
        check({tag, "_first"}, first, 0);
        check({tag, "_idx"}, bit_idx, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    logic exp_a6 [6] = '{0, 1, 1, 0, 1, 0};
    logic exp_b6 [6] = '{1, 1, 1, 0, 0, 0};

    initial begin
        int t0, t, base, c0;
        reset = 1'b1;
        key_r = 2'b11;
        sw_r  = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        check("reset_valid", bit_valid, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Six presses over A=10110, B=00111; SW disturbed after latch
        sw_r = {5'b00111, 5'b10110};
        base = log_n;
        press(1, D + 6, t0);
        check("latency", log_cyc[base], t0 + 1 + D + 2);
        for (int i = 1; i < 6; i++) begin
            press(1, D + 6, t);
            if (i == 1) sw_r = 10'h3ff;
        end
        check("six_count", log_n - base, 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("seq_a%0d", i), log_a[base+i], exp_a6[i]);
            check($sformatf("seq_b%0d", i), log_b[base+i], exp_b6[i]);
            check($sformatf("seq_idx%0d", i), log_idx[base+i], i);
            check($sformatf("seq_first%0d", i), log_first[base+i], (i == 0));
        end
        check("done_after6", done, 1);
        check("busy_after6", busy, 0);
        press(1, D + 6, t);
        check("done_ignores_step", log_n - base, 6);

        c0 = clr_n;
        press(0, D + 6, t);
        check("clear_count", clr_n - c0, 1);
        check_idle_zero("clear");

        // Long hold gives one event; release and re-press gives the next
        sw_r = {5'b11001, 5'b01101};
        base = log_n;
        press(1, 100, t);
        press(1, D + 6, t);
        check("hold_count", log_n - base, 2);
        check("hold_idx0", log_idx[base], 0);
        check("hold_idx1", log_idx[base+1], 1);
        check("hold_a0", log_a[base], 1);
        check("hold_a1", log_a[base+1], 0);
        check("hold_b0", log_b[base], 1);
        press(1, D + 6, t);

        // Clear after three bits, then restart with new operands
        press(0, D + 6, t);
        check_idle_zero("clear3");
        sw_r = {5'b10000, 5'b00011};
        base = log_n;
        press(1, D + 6, t);
        check("restart_count", log_n - base, 1);
        check("restart_idx", log_idx[base], 0);
        check("restart_first", log_first[base], 1);
        check("restart_a", log_a[base], 1);
        check("restart_b", log_b[base], 0);

        // Bouncing step key, then a clean hold
        press(0, D + 6, t);
        base = log_n;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            key_r[1] = ((i / 2) % 2 == 1);
        end
        @(negedge clk);
        t0 = cyc;
        key_r[1] = 1'b0;
        repeat (20) @(negedge clk);
        key_r[1] = 1'b1;
        repeat (D + 6) @(negedge clk);
        check("bounce_count", log_n - base, 1);
        check("bounce_latency", log_cyc[base], t0 + 1 + D + 2);

        // Clear and step debounced together: clear wins
        base = log_n;
        c0 = clr_n;
        @(negedge clk);
        key_r = 2'b00;
        repeat (D + 6) @(negedge clk);
        key_r = 2'b11;
        repeat (D + 6) @(negedge clk);
        check("both_valid", log_n - base, 0);
        check("both_clear", clr_n - c0, 1);
        check_idle_zero("both");

        // Reset in the middle of a shift
        base = log_n;
        for (int i = 0; i < 3; i++) press(1, D + 6, t);
        check("pre_reset_idx", bit_idx, 2);
        check("pre_reset_busy", busy, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_idle_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        base = log_n;
        press(1, D + 6, t);
        check("post_reset_count", log_n - base, 1);
        check("post_reset_idx", log_idx[base], 0);
        check("post_reset_first", log_first[base], 1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_operand_feeder.md
SERIAL_OPERAND_FEEDER -- requirements
Module: serial_operand_feeder

Interface
REQ-001 SHALL provide parameter WIDTH, default 5: operand width in bits.
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 500000: stable-sample count required to accept a key change (10 ms at 50 MHz).
REQ-003 SHALL have port MAX10_CLK1_50, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port KEY, input, 2 bits, active-low raw buttons: KEY[1] = step, KEY[0] = clear.
REQ-006 SHALL have port SW, input, 10 bits: SW[4:0] = operand A, SW[9:5] = operand B (at WIDTH=5).
REQ-007 SHALL have port a, output, 1 bit: current A bit.
REQ-008 SHALL have port b, output, 1 bit: current B bit.
REQ-009 SHALL have port first, output, 1 bit: high while bit_idx = 0 is presented; the consumer zeroes its carry when it sees first.
REQ-010 SHALL have port bit_valid, output, 1 bit: one-cycle strobe marking a new a/b/bit_idx.
REQ-011 SHALL have port bit_idx, output, 3 bits: index of the presented bit, range 0..WIDTH.
REQ-012 SHALL have port busy, output, 1 bit: high in SHIFT and FLUSH.
REQ-013 SHALL have port done, output, 1 bit: high in DONE.
REQ-014 SHALL have port clear_pulse, output, 1 bit: one-cycle strobe on an accepted clear press.

Function
REQ-015 Each KEY bit SHALL pass through a 2-flop synchronizer; both flops reset to 1.
REQ-016 Each key SHALL have a debounce counter.
- Counter increments each cycle the synchronized value differs from the stable value.
- Counter clears whenever they match.
- When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the stable value flips and the counter clears.
REQ-017 A press event SHALL be a stable 1->0 transition, valid for exactly one cycle; releases generate no event.
REQ-018 Latency: with KEY first sampled low at edge 0 and held, the FSM SHALL act at edge DEBOUNCE_CYCLES+2.
REQ-019 FSM states SHALL be IDLE, SHIFT, FLUSH and DONE.
REQ-020 IDLE + step press:
- latch A = SW[4:0] and B = SW[9:5];
- present a=A[0], b=B[0], bit_idx=0, first=1;
- pulse bit_valid;
- go to SHIFT.
REQ-021 SHIFT + step press: present bit_idx+1 (a=A[idx], b=B[idx], first=0) and pulse bit_valid; when the new idx equals WIDTH-1, go to FLUSH.
REQ-022 FLUSH + step press: present a=0, b=0, bit_idx=WIDTH (carry-out bit), pulse bit_valid, go to DONE.
REQ-023 DONE SHALL ignore step presses.
REQ-024 Clear press in any state SHALL:
- go to IDLE;
- pulse clear_pulse;
- zero a, b, first and bit_idx on the same edge.
REQ-025 Clear and step press in the same cycle: clear SHALL win and bit_valid SHALL stay low.
REQ-026 a, b, first and bit_idx SHALL hold their values between emissions.
REQ-027 SW changes after the latch SHALL have no effect until the next start from IDLE.
REQ-028 A held key SHALL produce exactly one event; the next event requires release (debounced) and a fresh press.

Reset
REQ-029 When reset is high at an edge, the block SHALL enter IDLE with all outputs 0.
- Stable key values and synchronizers set to 1; debounce counters set to 0.
- Applies in any state, including mid-SHIFT.
REQ-030 Key activity while reset is high SHALL generate no events after reset deasserts, unless the press is re-debounced.

Verification (DEBOUNCE_CYCLES=4, WIDTH=5)
REQ-031 A=10110, B=00111, six clean presses -> (a,b,idx) = (0,1,0), (1,1,1), (1,1,2), (0,0,3), (1,0,4), (0,0,5); first only on idx 0; done=1 after the sixth press.
REQ-032 KEY[1] toggling every 2 cycles for 20 cycles, then held low -> exactly one bit_valid, at edge 22+4+2 counted from the final low sample.
REQ-033 KEY[1] held low 100 cycles, released, pressed again -> exactly two bit_valid strobes, idx 0 then 1.
REQ-034 Clear after 3 bits -> clear_pulse, busy=0, outputs 0; changing SW then pressing step -> new operands latched, idx 0, first=1.
REQ-035 Clear and step debounced in the same cycle -> clear_pulse=1, bit_valid=0, state IDLE.
REQ-036 reset pulsed in SHIFT (idx 2) -> all outputs 0 on that edge; the next press starts at idx 0.
